// File: rtl/wide_adder_seq.sv
// wide_adder_seq: WORDS x 32-bit add sequenced through one 32-bit adder.
// Optional SUB_EN macro enables a - b through the same datapath.
module FullAdder_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, cin_i};
endmodule

module wide_adder_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   sum,
    output logic                  cout
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                  state_q, state_d;
    logic [WORDS-1:0][31:0]  a_q, b_q, sum_q;
    logic [IW-1:0]           idx_q;
    logic                    carry_q;
    logic                    cout_q;
    logic                    accept;
    logic                    init_carry;
    logic [31:0]             b_slice;
    logic [31:0]             add_sum;
    logic                    add_cout;

    assign accept = (state_q == IDLE) && start;

`ifdef SUB_EN
    logic sub_q;
    // Two's complement subtract: invert B and inject the +1 as carry-in.
    assign init_carry = sub ? 1'b1 : cin;
    assign b_slice    = sub_q ? ~b_q[idx_q] : b_q[idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= sub;
        end
    end
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign init_carry = cin;
    assign b_slice    = b_q[idx_q];
`endif

    FullAdder_32bit u_add (
        .a_i    (a_q[idx_q]),
        .b_i    (b_slice),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            idx_q   <= '0;
            carry_q <= init_carry;
        end else if (state_q == RUN) begin
            sum_q[idx_q] <= add_sum;
            carry_q      <= add_cout;
            idx_q        <= idx_q + 1'b1;
            if (idx_q == LAST) begin
                cout_q <= add_cout;
                idx_q  <= '0;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_wide_adder_seq.sv
// tb_wide_adder_seq: directed and random checks of wide_adder_seq
// for WORDS=4 and WORDS=1 against hand values and a+b+cin.
module tb_wide_adder_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         start4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0;
    logic [127:0] a4 = '0, b4 = '0;
    logic         busy4, done4, cout4;
    logic [127:0] sum4;

    logic         start1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
    logic [31:0]  a1 = '0, b1 = '0;
    logic         busy1, done1, cout1;
    logic [31:0]  sum1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wide_adder_seq #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    wide_adder_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [128:0] got,
                       input logic [128:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after E(WORDS+1).
    task automatic op4(input string tag, input logic [127:0] av,
                       input logic [127:0] bv, input logic ci,
                       input logic su, input bit hold,
                       input logic [127:0] na, input logic [127:0] nb,
                       input logic [128:0] exp);
        int nbusy, lat;
        a4 = av; b4 = bv; cin4 = ci; sub4 = su; start4 = 1'b1;
        @(posedge clk); #1;
        if (!hold) start4 = 1'b0;
        a4 = na; b4 = nb;
        nbusy = 0; lat = 0;
        for (int k = 0; k < 20; k++) begin
            if (done4) break;
            if (busy4) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_done_seen"}, {128'b0, done4}, 129'd1);
        chk({tag, "_latency"}, 129'(lat), 129'd4);
        chk({tag, "_busy_cycles"}, 129'(nbusy), 129'd4);
        chk({tag, "_busy_at_done"}, {128'b0, busy4}, 129'd0);
        chk({tag, "_result"}, {cout4, sum4}, exp);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, {128'b0, done4}, 129'd0);
        start4 = 1'b0;
    endtask

    task automatic op1(input string tag, input logic [31:0] av,
                       input logic [31:0] bv, input logic ci,
                       input logic [32:0] exp);
        int nbusy, lat;
        a1 = av; b1 = bv; cin1 = ci; sub1 = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        a1 = ~av; b1 = ~bv;
        nbusy = 0; lat = 0;
        for (int k = 0; k < 10; k++) begin
            if (done1) break;
            if (busy1) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_w1_lat"}, 129'(lat), 129'd1);
        chk({tag, "_w1_busy"}, 129'(nbusy), 129'd1);
        chk({tag, "_w1_result"}, {96'b0, cout1, sum1}, {96'b0, exp});
        @(posedge clk); #1;
        chk({tag, "_w1_done_off"}, {128'b0, done1}, 129'd0);
    endtask

    initial begin
        logic [127:0] ra, rb, ones;
        logic [31:0]  sa, sb;
        logic         rc;
        int           ndone;
        ones = '1;

        #2;
        chk("rst_busy4", {128'b0, busy4}, 129'd0);
        chk("rst_done4", {128'b0, done4}, 129'd0);
        chk("rst_res4", {cout4, sum4}, 129'd0);
        chk("rst_res1", {96'b0, cout1, sum1}, 129'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        op4("carry32", 128'hFFFF_FFFF, 128'd1, 1'b0, 1'b0, 1'b0,
            128'hFFFF_FFFF, 128'd1, {1'b0, 128'h1_0000_0000});
        op4("ripple", ones, 128'd0, 1'b1, 1'b0, 1'b0,
            ones, 128'd0, {1'b1, 128'd0});
        op4("cin_only", 128'd0, 128'd0, 1'b1, 1'b0, 1'b0,
            128'd0, 128'd0, 129'd1);

        op4("hold", 128'h10, 128'h20, 1'b0, 1'b0, 1'b1,
            ones, ones, 129'h30);
        op4("b2b", 128'd2, 128'd3, 1'b0, 1'b0, 1'b0,
            128'd2, 128'd3, 129'd5);

        a4 = {32'd1, 32'd2, 32'd3, 32'd4};
        b4 = {32'd1, 32'd1, 32'd1, 32'd1};
        cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("partial_sum", {1'b0, sum4}, {65'b0, 32'd4, 32'd5});
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {128'b0, busy4}, 129'd0);
        chk("arst_done", {128'b0, done4}, 129'd0);
        chk("arst_res", {cout4, sum4}, 129'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done4 || busy4) ndone++;
        end
        chk("arst_no_done", 129'(ndone), 129'd0);
        op4("after_rst", 128'd5, 128'd7, 1'b0, 1'b0, 1'b0,
            128'd5, 128'd7, 129'd12);

`ifdef SUB_EN
        op4("sub_0m1", 128'd0, 128'd1, 1'b0, 1'b1, 1'b0,
            128'd0, 128'd1, {1'b0, ones});
        op4("sub_5m3", 128'd5, 128'd3, 1'b0, 1'b1, 1'b0,
            128'd5, 128'd3, {1'b1, 128'd2});
`else
        op4("sub_off_0p1", 128'd0, 128'd1, 1'b0, 1'b1, 1'b0,
            128'd0, 128'd1, 129'd1);
        op4("sub_off_5p3", 128'd5, 128'd3, 1'b0, 1'b1, 1'b0,
            128'd5, 128'd3, 129'd8);
`endif

        op1("w1_wrap", 32'hFFFF_FFFF, 32'd0, 1'b1, {1'b1, 32'd0});
        op1("w1_small", 32'd5, 32'd7, 1'b1, 33'd13);

        for (int i = 0; i < 200; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            if (i % 10 == 0) rb = ~ra;
            op4("rand4", ra, rb, rc, 1'b0, 1'b0, ~ra, ~rb,
                {1'b0, ra} + {1'b0, rb} + {128'b0, rc});
        end
        for (int i = 0; i < 200; i++) begin
            sa = $urandom;
            sb = $urandom;
            rc = 1'($urandom_range(0, 1));
            if (i % 10 == 0) sb = ~sa;
            op1("rand1", sa, sb, rc,
                {1'b0, sa} + {1'b0, sb} + {32'b0, rc});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wide_adder_seq.md
# wide_adder_seq

Multi-cycle sequencer that performs WORDS×32-bit additions by time-multiplexing a single FullAdder_32bit instance. Each RUN cycle feeds one 32-bit slice, least significant first, and chains the carry-out of one slice into the carry-in of the next. It sits between a requesting master (start/done handshake) and the shared 32-bit adder datapath, so operand widths beyond 32 bits need no extra adder hardware.

## Interface
- WORDS, default 4: number of 32-bit slices per operation; legal range 1..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- a  in  32*WORDS  operand A; captured on the accepting edge.
- b  in  32*WORDS  operand B; captured on the accepting edge.
- cin  in  1  initial carry-in; captured on the accepting edge.
- sub  in  1  subtract request; captured on the accepting edge. Ignored unless SUB_EN is defined.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- sum  out  32*WORDS  result register.
- cout  out  1  final carry-out of the most significant slice.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- IDLE, start=1: capture a, b, cin, sub into internal registers; idx←0; carry←cin; go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - Adder inputs: A=a_reg[idx], B=b_reg[idx], Cin=carry.
  - On the edge: sum[idx]←Sum; carry←Cout; idx←idx+1.
  - When idx=WORDS-1: cout←Cout; go to DONE.
- DONE: done=1 for exactly one cycle; unconditionally return to IDLE.
- start in RUN or DONE is ignored and not queued.
- Operands may change after acceptance without effect on the operation in progress.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(32*WORDS+1). Slices are ordered little-endian: word i = bits [32i+31:32i].
- sum is written slice by slice during RUN, so partial values are visible. sum is valid from the done cycle and holds until the next accepted start writes slice 0.
- WORDS=1: exactly one RUN cycle.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - idx, carry and operand registers = 0.
- Reset is effective immediately, including mid-RUN. The aborted operation produces no done pulse.
- Edge E0 samples start=1 in IDLE. busy=1 after E0.
- Edges E1..E(WORDS) write slices 0..WORDS-1.
- After edge E(WORDS): busy=0, done=1.
- After edge E(WORDS+1): done=0, state=IDLE.
- Accept-to-done latency is WORDS cycles. Start-to-start throughput is WORDS+2 cycles: the earliest new accept is edge E(WORDS+2).
- The adder path is combinational, from registered slice to registered sum word, within one cycle.

## Configuration
- SUB_EN defined:
  - When sub was captured as 1, B slices feed the adder as ~b_reg[idx] and the initial carry is forced to 1; cin is ignored. Result is a − b.
  - cout=1 means no borrow; cout=0 means borrow.
  - When sub was captured as 0, behaviour is identical to the undefined case.
- SUB_EN undefined: the sub port is present but unused, and only addition is performed.

## Test plan
- WORDS=4, a=0x00000000_00000000_00000000_FFFFFFFF, b=1, cin=0 → sum=0x00000000_00000000_00000001_00000000, cout=0. done pulses 4 cycles after the accepting edge, for exactly 1 cycle.
- WORDS=4, a=all ones, b=0, cin=1 → sum=0, cout=1 (carry ripples through all slices). Repeat with a=b=0, cin=1 → sum=1, cout=0.
- Accept start, hold start=1 through RUN and DONE → exactly one done pulse per accepted start. Change a/b during RUN → result matches the captured operands. A new start at E(WORDS+2) is accepted.
- Assert rst_n=0 after the second RUN edge → busy, done, sum and cout are 0 immediately and no done follows. A subsequent op 5+7 returns sum=12.
- SUB_EN defined: a=0, b=1, sub=1 → sum=all ones, cout=0. a=5, b=3, sub=1 → sum=2, cout=1. SUB_EN undefined: a=0, b=1, sub=1 → sum=1.
- 200 random operations with WORDS=1 and WORDS=4 against the golden model {cout,sum}=a+b+cin → zero mismatches. busy=1 for exactly WORDS cycles per operation.
